// File: rtl/ser8_pkg.sv
// Shared definitions for the 8-bit serializer: word/select widths and FSM states.
package ser8_pkg;
    localparam int WORD_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/serializer8_mux8to1.sv
// 8-to-1 bit multiplexer: presents in[sel] on out.
module mux8to1
    import ser8_pkg::*;
(
    input  logic [WORD_W-1:0] in,
    input  logic [SEL_W-1:0]  sel,
    output logic              out
);
    // Pure combinational bit pick.
    always_comb begin
        out = in[sel];
    end
endmodule

// File: rtl/serializer8.sv
// Parallel-to-serial converter. One word shifts out of active_word while a
// second word may wait in a one-entry pending register, so consecutive words
// stream without an idle cycle between them.
//
// Handshake: a word moves upstream->block when in_valid && in_ready on a rising
// clk edge; a bit moves block->downstream when out_valid && out_ready on a
// rising edge. in_ready and out_valid depend on registered state only, never on
// the partner's valid/ready in the same cycle.
module serializer8
    import ser8_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SEL_W-1:0]  sel,
    output logic              out_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              last,
    output logic              busy
);
    // First and final bit index of a word for the chosen bit order.
    localparam logic [SEL_W-1:0] START_SEL = LSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [SEL_W-1:0] FINAL_SEL = LSB_FIRST ? 3'd7 : 3'd0;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [WORD_W-1:0]  active_q, active_d;
    logic [WORD_W-1:0]  pend_q, pend_d;
    logic               pend_full_q, pend_full_d;
    logic               in_fire;
    logic               out_fire;

    // Handshake outputs derived from registered state only.
    always_comb begin
        busy      = (state_q == SHIFT);
        out_valid = (state_q == SHIFT);
        in_ready  = (state_q == IDLE) || !pend_full_q;
        last      = (state_q == SHIFT) && (sel_q == FINAL_SEL);
        sel       = sel_q;
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
    end

    // State, select and word registers; reset discards any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= START_SEL;
            active_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
        end
    end

    // Next-state logic: load, step, reload from pending/bypass, or go idle.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    active_d = in_data;
                    sel_d    = START_SEL;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (out_fire && last) begin
                    sel_d = START_SEL;
                    if (pend_full_q) begin
                        // in_ready is low here, so no input can arrive this cycle.
                        active_d    = pend_q;
                        pend_full_d = 1'b0;
                    end else if (in_fire) begin
                        active_d = in_data;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (out_fire) begin
                        sel_d = LSB_FIRST ? sel_q + 3'd1 : sel_q - 3'd1;
                    end
                    if (in_fire) begin
                        pend_d      = in_data;
                        pend_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mux8to1 u_mux (
        .in  (active_q),
        .sel (sel_q),
        .out (out_bit)
    );
endmodule

// File: tb/tb_serializer8.sv
// Bench for serializer8: one LSB-first and one MSB-first instance share the
// same stimulus and are compared every cycle against a queue-of-words model.
module tb_serializer8;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready_a, out_bit_a, out_valid_a, last_a, busy_a;
    logic [2:0] sel_a;
    logic       in_ready_b, out_bit_b, out_valid_b, last_b, busy_b;
    logic [2:0] sel_b;

    int checks   = 0;
    int failures = 0;

    // Reference model: words in flight (head is being shifted), bits sent of head.
    logic [7:0] mq[$];
    int         pos;
    logic       obs_a[$];
    logic       obs_b[$];
    int         valid_cycles;
    bit         last_in_fire;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    serializer8 #(.LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .sel(sel_a), .out_bit(out_bit_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .last(last_a), .busy(busy_a)
    );

    serializer8 #(.LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .sel(sel_b), .out_bit(out_bit_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .last(last_b), .busy(busy_b)
    );

    // ---------------- per-cycle scoreboard step ----------------
    // Compares both DUTs to the model, then advances one clock edge.
    task automatic step();
        logic       e_valid, e_ready, e_last;
        logic [2:0] e_sel_a, e_sel_b;
        logic       e_bit_a, e_bit_b;
        bit         in_fire, out_fire;
        e_valid = (mq.size() > 0);
        e_ready = (mq.size() < 2);
        e_last  = e_valid && (pos == 7);
        e_sel_a = 3'(pos);
        e_sel_b = 3'(7 - pos);
        e_bit_a = e_valid ? mq[0][e_sel_a] : 1'b0;
        e_bit_b = e_valid ? mq[0][e_sel_b] : 1'b0;

        checks += 8;
        if (out_valid_a !== e_valid || out_valid_b !== e_valid) begin
            failures++;
            $display("FAIL out_valid t=%0t got a=%b b=%b exp %b", $time, out_valid_a, out_valid_b, e_valid);
        end
        if (busy_a !== e_valid || busy_b !== e_valid) begin
            failures++;
            $display("FAIL busy t=%0t got a=%b b=%b exp %b", $time, busy_a, busy_b, e_valid);
        end
        if (in_ready_a !== e_ready || in_ready_b !== e_ready) begin
            failures++;
            $display("FAIL in_ready t=%0t got a=%b b=%b exp %b", $time, in_ready_a, in_ready_b, e_ready);
        end
        if (last_a !== e_last || last_b !== e_last) begin
            failures++;
            $display("FAIL last t=%0t got a=%b b=%b exp %b", $time, last_a, last_b, e_last);
        end
        if (e_valid) begin
            if (sel_a !== e_sel_a) begin
                failures++;
                $display("FAIL sel_lsb t=%0t got %0d exp %0d", $time, sel_a, e_sel_a);
            end
            if (sel_b !== e_sel_b) begin
                failures++;
                $display("FAIL sel_msb t=%0t got %0d exp %0d", $time, sel_b, e_sel_b);
            end
            if (out_bit_a !== e_bit_a) begin
                failures++;
                $display("FAIL out_bit_lsb t=%0t got %b exp %b", $time, out_bit_a, e_bit_a);
            end
            if (out_bit_b !== e_bit_b) begin
                failures++;
                $display("FAIL out_bit_msb t=%0t got %b exp %b", $time, out_bit_b, e_bit_b);
            end
        end else begin
            checks -= 4;
        end

        if (out_valid_a === 1'b1) valid_cycles++;
        in_fire  = in_valid && e_ready;
        out_fire = e_valid && out_ready;
        if (out_fire) begin
            obs_a.push_back(out_bit_a);
            obs_b.push_back(out_bit_b);
        end
        last_in_fire = in_fire;

        @(posedge clk);
        if (out_fire) begin
            pos++;
            if (pos == 8) begin
                void'(mq.pop_front());
                pos = 0;
            end
        end
        if (in_fire) mq.push_back(in_data);
        #1;
    endtask

    task automatic clear_obs();
        obs_a.delete();
        obs_b.delete();
        valid_cycles = 0;
    endtask

    // Assemble observed bits back into a word in each instance's order.
    function automatic logic [7:0] word_lsb();
        logic [7:0] w = '0;
        for (int i = 0; i < 8 && i < obs_a.size(); i++) w[i] = obs_a[i];
        return w;
    endfunction

    function automatic logic [7:0] word_msb();
        logic [7:0] w = '0;
        for (int i = 0; i < 8 && i < obs_b.size(); i++) w[7 - i] = obs_b[i];
        return w;
    endfunction

    // ---------------- driver tasks / scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        mq.delete(); pos = 0;
        #12;
        checks += 4;
        if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid_busy got %b%b%b%b exp 0000", out_valid_a, out_valid_b, busy_a, busy_b);
        end
        if (last_a !== 1'b0 || last_b !== 1'b0 || out_bit_a !== 1'b0 || out_bit_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_last_bit got %b%b%b%b exp 0000", last_a, last_b, out_bit_a, out_bit_b);
        end
        if (sel_a !== 3'd0 || sel_b !== 3'd7) begin
            failures++;
            $display("FAIL reset_sel got a=%0d b=%0d exp 0 7", sel_a, sel_b);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got a=%b b=%b exp 1", in_ready_a, in_ready_b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_word();
        clear_obs();
        out_ready = 1'b1;
        in_data = 8'b1010_0111; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_data = 8'h00;
        for (int i = 0; i < 10; i++) step();
        checks += 3;
        if (word_lsb() !== 8'hA7 || obs_a.size() != 8) begin
            failures++;
            $display("FAIL single_lsb got %h (%0d bits) exp a7 (8 bits)", word_lsb(), obs_a.size());
        end
        if (word_msb() !== 8'hA7) begin
            failures++;
            $display("FAIL single_msb got %h exp a7", word_msb());
        end
        if (valid_cycles != 8) begin
            failures++;
            $display("FAIL single_valid_cycles got %0d exp 8", valid_cycles);
        end
    endtask

    task automatic test_out_ready_toggle();
        clear_obs();
        out_ready = 1'b1;
        in_data = 8'hA5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            out_ready = (i % 2 == 0);
            step();
        end
        out_ready = 1'b1;
        step();
        checks += 2;
        if (obs_a.size() != 8) begin
            failures++;
            $display("FAIL toggle_transfers got %0d exp 8", obs_a.size());
        end
        if (word_lsb() !== 8'hA5) begin
            failures++;
            $display("FAIL toggle_word got %h exp a5", word_lsb());
        end
    endtask

    task automatic test_back_to_back();
        int accepted = 0;
        clear_obs();
        out_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            in_valid = (accepted < 2);
            in_data  = (accepted == 0) ? 8'h0F : 8'hF0;
            step();
            if (last_in_fire) accepted++;
        end
        in_valid = 1'b0;
        checks += 2;
        if (valid_cycles != 16) begin
            failures++;
            $display("FAIL b2b_valid_cycles got %0d exp 16", valid_cycles);
        end
        if (obs_a.size() != 16) begin
            failures++;
            $display("FAIL b2b_transfers got %0d exp 16", obs_a.size());
        end
    endtask

    task automatic test_bypass();
        clear_obs();
        out_ready = 1'b1;
        in_data = 8'h3C; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && pos != 7; i++) step();
        in_data = 8'hC3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks += 1;
        if (sel_a !== 3'd0 || out_valid_a !== 1'b1 || sel_b !== 3'd7) begin
            failures++;
            $display("FAIL bypass_reload got sel a=%0d b=%0d valid=%b exp 0 7 1", sel_a, sel_b, out_valid_a);
        end
        for (int i = 0; i < 10; i++) step();
        checks += 1;
        if (valid_cycles != 16) begin
            failures++;
            $display("FAIL bypass_valid_cycles got %0d exp 16", valid_cycles);
        end
    endtask

    task automatic test_reset_mid_word();
        clear_obs();
        out_ready = 1'b1;
        in_data = 8'hFF; in_valid = 1'b1;
        step();
        in_data = 8'hFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && pos != 4; i++) step();
        #2;
        rst = 1'b1;
        #1;
        mq.delete(); pos = 0;
        checks += 2;
        if (out_valid_a !== 1'b0 || busy_a !== 1'b0 || last_a !== 1'b0 || out_bit_a !== 1'b0 || sel_a !== 3'd0) begin
            failures++;
            $display("FAIL midreset_lsb got v=%b b=%b l=%b o=%b s=%0d exp 0 0 0 0 0",
                     out_valid_a, busy_a, last_a, out_bit_a, sel_a);
        end
        if (out_valid_b !== 1'b0 || out_bit_b !== 1'b0 || sel_b !== 3'd7) begin
            failures++;
            $display("FAIL midreset_msb got v=%b o=%b s=%0d exp 0 0 7", out_valid_b, out_bit_b, sel_b);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        clear_obs();
        for (int i = 0; i < 12; i++) step();
        checks += 1;
        if (valid_cycles != 0) begin
            failures++;
            $display("FAIL midreset_resume got %0d valid cycles exp 0", valid_cycles);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom_range(0, 255));
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_single_word();
        test_out_ready_toggle();
        test_back_to_back();
        test_bypass();
        test_reset_mid_word();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
